// File: rtl/async_valid_sync_multi.sv
// Multi-channel level synchronizer with optional glitch filter and edge pulses.
// Every output is driven from registers, so no path runs from io_in to an output.
module async_valid_sync_multi #(
    parameter int               WIDTH  = 1,
    parameter int               DEPTH  = 3,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int               FILTER = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic             io_any_edge
);

    logic [WIDTH-1:0] r_sync [DEPTH];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_out;

    // NOTE: every stage is reset to INIT so a release with io_in == INIT yields no pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_sync[s] <= INIT;
            end
        end else begin
            r_sync[0] <= io_in;
            for (int s = 1; s < DEPTH; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[DEPTH-1];

    generate
        if (FILTER == 0) begin : g_no_filter
            assign w_out = w_sync;
        end else begin : g_filter
            localparam int CW = $clog2(FILTER + 1);

            logic [WIDTH-1:0] r_out;
            logic [CW-1:0]    r_cnt [WIDTH];

            // The counter only runs while sync disagrees with the output; any agreement restarts it.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_out <= INIT;
                    for (int ch = 0; ch < WIDTH; ch++) begin
                        r_cnt[ch] <= '0;
                    end
                end else begin
                    for (int ch = 0; ch < WIDTH; ch++) begin
                        if (w_sync[ch] == r_out[ch]) begin
                            r_cnt[ch] <= '0;
                        end else if (r_cnt[ch] == CW'(FILTER - 1)) begin
                            r_out[ch] <= w_sync[ch];
                            r_cnt[ch] <= '0;
                        end else begin
                            r_cnt[ch] <= r_cnt[ch] + CW'(1);
                        end
                    end
                end
            end

            assign w_out = r_out;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev <= INIT;
        end else begin
            r_prev <= w_out;
        end
    end

    assign io_out      = w_out;
    assign io_rise     = w_out & ~r_prev;
    assign io_fall     = ~w_out & r_prev;
    assign io_any_edge = |(io_rise | io_fall);

endmodule

// File: tb/tb_async_valid_sync_multi.sv
// Directed bench: four parameterisations of async_valid_sync_multi checked against
// hand-computed latencies and pulse patterns. Inputs change and outputs are sampled on negedges.
module tb_async_valid_sync_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_f4_n;
    int         checks = 0;
    int         errors = 0;

    // WIDTH=4, DEPTH=3, FILTER=0, INIT=0
    logic [3:0] f0_in, f0_out, f0_rise, f0_fall;
    logic       f0_any;
    // WIDTH=4, DEPTH=3, FILTER=4, INIT=0
    logic [3:0] f4_in, f4_out, f4_rise, f4_fall;
    logic       f4_any;
    // WIDTH=4, DEPTH=3, FILTER=0, INIT=1010
    logic [3:0] in_in, in_out, in_rise, in_fall;
    logic       in_any;
    // WIDTH=1, DEPTH=2, FILTER=0
    logic       d2_in, d2_out, d2_rise, d2_fall, d2_any;

    always #5 clk = ~clk;

    async_valid_sync_multi #(.WIDTH(4), .DEPTH(3), .INIT(4'b0000), .FILTER(0)) u_f0 (
        .clock(clk), .reset(rst_n), .io_in(f0_in), .io_out(f0_out),
        .io_rise(f0_rise), .io_fall(f0_fall), .io_any_edge(f0_any));

    async_valid_sync_multi #(.WIDTH(4), .DEPTH(3), .INIT(4'b0000), .FILTER(4)) u_f4 (
        .clock(clk), .reset(rst_f4_n), .io_in(f4_in), .io_out(f4_out),
        .io_rise(f4_rise), .io_fall(f4_fall), .io_any_edge(f4_any));

    async_valid_sync_multi #(.WIDTH(4), .DEPTH(3), .INIT(4'b1010), .FILTER(0)) u_init (
        .clock(clk), .reset(rst_n), .io_in(in_in), .io_out(in_out),
        .io_rise(in_rise), .io_fall(in_fall), .io_any_edge(in_any));

    async_valid_sync_multi #(.WIDTH(1), .DEPTH(2), .INIT(1'b0), .FILTER(0)) u_d2 (
        .clock(clk), .reset(rst_n), .io_in(d2_in), .io_out(d2_out),
        .io_rise(d2_rise), .io_fall(d2_fall), .io_any_edge(d2_any));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        // Sampled while reset is still held low, after several reset edges.
        checks++;
        if (f0_out !== 4'b0000 || f0_rise !== 4'b0000 || f0_fall !== 4'b0000 || f0_any !== 1'b0) begin
            $display("FAIL reset_f0 out=%b rise=%b fall=%b any=%b exp 0000/0000/0000/0", f0_out, f0_rise, f0_fall, f0_any);
            errors++;
        end
        checks++;
        if (f4_out !== 4'b0000 || f4_any !== 1'b0) begin
            $display("FAIL reset_f4 out=%b any=%b exp 0000/0", f4_out, f4_any);
            errors++;
        end
        checks++;
        if (in_out !== 4'b1010 || in_rise !== 4'b0000 || in_fall !== 4'b0000 || in_any !== 1'b0) begin
            $display("FAIL reset_init out=%b rise=%b fall=%b any=%b exp 1010/0000/0000/0", in_out, in_rise, in_fall, in_any);
            errors++;
        end
    endtask

    task automatic test_init_release();
        // io_in already equals INIT, so nothing must move across release.
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checks++;
            if (in_out !== 4'b1010 || in_rise !== 4'b0000 || in_fall !== 4'b0000 || in_any !== 1'b0) begin
                $display("FAIL init_release cyc%0d out=%b rise=%b fall=%b exp 1010/0000/0000", i, in_out, in_rise, in_fall);
                errors++;
            end
        end
    endtask

    task automatic test_f0_latency();
        f0_in = 4'b0101;
        tick(2);
        checks++;
        if (f0_out !== 4'b0000 || f0_any !== 1'b0) begin
            $display("FAIL f0_edge2 out=%b any=%b exp 0000/0", f0_out, f0_any);
            errors++;
        end
        tick(1);
        checks++;
        if (f0_out !== 4'b0101 || f0_rise !== 4'b0101 || f0_fall !== 4'b0000 || f0_any !== 1'b1) begin
            $display("FAIL f0_edge3 out=%b rise=%b fall=%b any=%b exp 0101/0101/0000/1", f0_out, f0_rise, f0_fall, f0_any);
            errors++;
        end
        tick(1);
        checks++;
        if (f0_out !== 4'b0101 || f0_rise !== 4'b0000 || f0_any !== 1'b0) begin
            $display("FAIL f0_edge4 out=%b rise=%b any=%b exp 0101/0000/0", f0_out, f0_rise, f0_any);
            errors++;
        end
    endtask

    task automatic test_simultaneous();
        f0_in = 4'b0011;
        tick(3);
        checks++;
        if (f0_out !== 4'b0011 || f0_rise !== 4'b0010 || f0_fall !== 4'b0100) begin
            $display("FAIL mix_0011 out=%b rise=%b fall=%b exp 0011/0010/0100", f0_out, f0_rise, f0_fall);
            errors++;
        end
        tick(2);
        f0_in = 4'b1001;
        tick(3);
        checks++;
        if (f0_out !== 4'b1001 || f0_rise !== 4'b1000 || f0_fall !== 4'b0010 || f0_any !== 1'b1) begin
            $display("FAIL mix_1001 out=%b rise=%b fall=%b any=%b exp 1001/1000/0010/1", f0_out, f0_rise, f0_fall, f0_any);
            errors++;
        end
        tick(1);
        checks++;
        if (f0_rise !== 4'b0000 || f0_fall !== 4'b0000 || f0_any !== 1'b0) begin
            $display("FAIL mix_after rise=%b fall=%b any=%b exp 0000/0000/0", f0_rise, f0_fall, f0_any);
            errors++;
        end
        f0_in = 4'b0000;
        tick(3);
        checks++;
        if (f0_out !== 4'b0000 || f0_fall !== 4'b1001 || f0_rise !== 4'b0000) begin
            $display("FAIL fall_all out=%b fall=%b rise=%b exp 0000/1001/0000", f0_out, f0_fall, f0_rise);
            errors++;
        end
    endtask

    task automatic test_filter_reject();
        f4_in = 4'b0001;
        tick(3);
        f4_in = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (f4_out !== 4'b0000 || f4_any !== 1'b0) begin
                $display("FAIL filter_reject cyc%0d out=%b any=%b exp 0000/0", i, f4_out, f4_any);
                errors++;
            end
        end
    endtask

    task automatic test_filter_accept();
        f4_in = 4'b0001;
        tick(4);
        f4_in = 4'b0000;
        tick(2);
        checks++;
        if (f4_out !== 4'b0000 || f4_any !== 1'b0) begin
            $display("FAIL filter_edge6 out=%b any=%b exp 0000/0", f4_out, f4_any);
            errors++;
        end
        tick(1);
        checks++;
        if (f4_out !== 4'b0001 || f4_rise !== 4'b0001 || f4_any !== 1'b1) begin
            $display("FAIL filter_edge7 out=%b rise=%b any=%b exp 0001/0001/1", f4_out, f4_rise, f4_any);
            errors++;
        end
        tick(1);
        checks++;
        if (f4_out !== 4'b0001 || f4_rise !== 4'b0000) begin
            $display("FAIL filter_edge8 out=%b rise=%b exp 0001/0000", f4_out, f4_rise);
            errors++;
        end
        // Input was high for edges 1..4, so sync drops after edge 7 and the output after edge 11.
        tick(3);
        checks++;
        if (f4_out !== 4'b0000 || f4_fall !== 4'b0001) begin
            $display("FAIL filter_edge11 out=%b fall=%b exp 0000/0001", f4_out, f4_fall);
            errors++;
        end
        tick(2);
    endtask

    task automatic test_filter_reset_mid();
        f4_in = 4'b0001;
        tick(5);
        rst_f4_n = 1'b0;
        tick(1);
        checks++;
        if (f4_out !== 4'b0000 || f4_rise !== 4'b0000 || f4_fall !== 4'b0000 || f4_any !== 1'b0) begin
            $display("FAIL midreset out=%b rise=%b fall=%b exp 0000/0000/0000", f4_out, f4_rise, f4_fall);
            errors++;
        end
        rst_f4_n = 1'b1;
        tick(6);
        checks++;
        if (f4_out !== 4'b0000 || f4_any !== 1'b0) begin
            $display("FAIL midreset_edge6 out=%b any=%b exp 0000/0", f4_out, f4_any);
            errors++;
        end
        tick(1);
        checks++;
        if (f4_out !== 4'b0001 || f4_rise !== 4'b0001) begin
            $display("FAIL midreset_edge7 out=%b rise=%b exp 0001/0001", f4_out, f4_rise);
            errors++;
        end
    endtask

    task automatic test_depth2();
        d2_in = 1'b1;
        tick(1);
        checks++;
        if (d2_out !== 1'b0) begin
            $display("FAIL d2_rise_edge1 out=%b exp 0", d2_out);
            errors++;
        end
        tick(1);
        checks++;
        if (d2_out !== 1'b1 || d2_rise !== 1'b1 || d2_any !== 1'b1) begin
            $display("FAIL d2_rise_edge2 out=%b rise=%b any=%b exp 1/1/1", d2_out, d2_rise, d2_any);
            errors++;
        end
        d2_in = 1'b0;
        tick(1);
        checks++;
        if (d2_out !== 1'b1 || d2_any !== 1'b0) begin
            $display("FAIL d2_fall_edge1 out=%b any=%b exp 1/0", d2_out, d2_any);
            errors++;
        end
        tick(1);
        checks++;
        if (d2_out !== 1'b0 || d2_fall !== 1'b1 || d2_rise !== 1'b0) begin
            $display("FAIL d2_fall_edge2 out=%b fall=%b rise=%b exp 0/1/0", d2_out, d2_fall, d2_rise);
            errors++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rst_f4_n = 1'b0;
        f0_in    = 4'b0000;
        f4_in    = 4'b0000;
        in_in    = 4'b1010;
        d2_in    = 1'b0;
        tick(3);
        test_reset();
        rst_n    = 1'b1;
        rst_f4_n = 1'b1;
        test_init_release();
        test_f0_latency();
        test_simultaneous();
        test_filter_reject();
        test_filter_accept();
        test_filter_reset_mid();
        test_depth2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
